// File: rtl/rmw_counter_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rmw_pkg
// Shared types and helpers for the read-modify-write counter arbiter.
//   rmw_state_e : controller state (INIT zeroes the memory, RUN serves ops)
//   rmw_req_t   : stage-1 request record {id, addr, delta}, sized for the
//                 widest legal configuration; users take the low bits
//   clog2       : ceil(log2(n)) for sizing the requester index
// ---------------------------------------------------------------------------
package rmw_pkg;

  localparam int RMW_ID_W_MAX   = 3;   // up to 8 requesters
  localparam int RMW_AW_MAX     = 16;
  localparam int RMW_DELW_MAX   = 32;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } rmw_state_e;

  typedef struct packed {
    logic [RMW_ID_W_MAX-1:0] id;
    logic [RMW_AW_MAX-1:0]   addr;
    logic [RMW_DELW_MAX-1:0] delta;
  } rmw_req_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rmw_counter_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// NREQ-wide round-robin arbiter. Searches req upward from the pointer
// (modulo NREQ) and grants the first asserted requester. The pointer moves to
// one past the winner whenever a grant is issued, otherwise it holds.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : arbitration enabled (no grant and no pointer move if low)
//   req          : request vector
//   grant        : one-hot or zero grant vector (combinational)
//   gid          : index of the granted requester (valid when grant != 0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid
);

  logic [IDW-1:0] rr_ptr_r;
  logic           found_s;
  logic [IDW-1:0] pick_s;
  logic [IDW-1:0] idx_s;
  int             idx_i;

  // Rotating priority search starting at the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDW{1'b0}};
    idx_i   = 0;
    idx_s   = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_i = int'(rr_ptr_r) + k;
      if (idx_i >= NREQ) begin
        idx_i = idx_i - NREQ;
      end else begin
        idx_i = idx_i;
      end
      idx_s = IDW'(idx_i);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant for the winner, only while enabled.
  always_comb begin
    grant = {NREQ{1'b0}};
    gid   = pick_s;
    if (en && found_s) begin
      grant[pick_s] = 1'b1;
    end else begin
      grant = {NREQ{1'b0}};
    end
  end

  // Pointer advances to one past the winner after every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= {IDW{1'b0}};
    end else if (en && found_s) begin
      rr_ptr_r <= (pick_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : pick_s + IDW'(1'b1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/rmw_counter_arbiter.sv
// ---------------------------------------------------------------------------
// rmw_counter_arbiter
// NREQ requesters share one DEPTH x DW counter memory. Each accepted request
// performs mem[addr] <= mem[addr] + delta and returns the new value two
// cycles after acceptance. An init sequencer zeroes the memory after reset
// and on clr; busy is high while it runs.
//
// Optional build macro: RMW_SATURATE_EN -- sums clamp at all-ones instead of
// wrapping, and the extra output sat_flag marks clamped responses.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : one-cycle pulse, restarts memory initialisation
//   req_valid    : per-requester valid        req_ready : per-requester grant
//   req_addr     : packed addresses, [i*AW +: AW]
//   req_delta    : packed increments, [i*DELW +: DELW]
//   rsp_valid    : one-cycle response strobe
//   rsp_id       : requester being answered   rsp_data  : post-update value
//   sat_flag     : (RMW_SATURATE_EN only) response was clamped
//   busy         : memory initialisation in progress
// ---------------------------------------------------------------------------
module rmw_counter_arbiter
  import rmw_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32,
  parameter int DELW  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DELW-1:0]    req_delta,
  output logic                    rsp_valid,
  output logic [clog2(NREQ)-1:0]  rsp_id,
  output logic [DW-1:0]           rsp_data,
`ifdef RMW_SATURATE_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  localparam int IDW = clog2(NREQ);

  rmw_state_e      state_r;
  logic [AW-1:0]   init_ptr_r;
  logic            arb_en_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  gid_s;
  logic            xfer_s;

  rmw_req_t        st1_r;
  logic            st1_valid_r;
  logic [IDW-1:0]  st1_id_s;
  logic [AW-1:0]   st1_addr_s;
  logic [DELW-1:0] st1_delta_s;
  logic            st1_unused_s;

  logic [DW-1:0]   mem_r [DEPTH];
  logic [DW-1:0]   rd_s;
  logic [DW-1:0]   delta_ext_s;
  logic [DW-1:0]   sum_s;
`ifdef RMW_SATURATE_EN
  logic [DW:0]     sum_ext_s;
  logic            sat_s;
`endif

  // clr blocks acceptance in its own cycle so no new op is lost to the restart.
  assign arb_en_s  = (state_r == RUN) && !clr;
  assign req_ready = grant_s;
  assign xfer_s    = |(req_valid & grant_s);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en_s),
    .req     (req_valid),
    .grant   (grant_s),
    .gid     (gid_s)
  );

  // Init sequencer / run controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= INIT;
      init_ptr_r <= {AW{1'b0}};
      busy       <= 1'b1;
    end else if (clr) begin
      state_r    <= INIT;
      init_ptr_r <= {AW{1'b0}};
      busy       <= 1'b1;
    end else begin
      case (state_r)
        INIT: begin
          init_ptr_r <= init_ptr_r + AW'(1'b1);
          if (init_ptr_r == AW'(DEPTH - 1)) begin
            state_r <= RUN;
            busy    <= 1'b0;
          end else begin
            state_r <= INIT;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          state_r    <= RUN;
          init_ptr_r <= init_ptr_r;
          busy       <= 1'b0;
        end
        default: begin
          state_r    <= INIT;
          init_ptr_r <= {AW{1'b0}};
          busy       <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1 capture of the accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_valid_r <= 1'b0;
      st1_r       <= '{default: 1'b0};
    end else if (xfer_s) begin
      st1_valid_r <= 1'b1;
      st1_r.id    <= RMW_ID_W_MAX'(gid_s);
      st1_r.addr  <= RMW_AW_MAX'(req_addr[int'(gid_s)*AW +: AW]);
      st1_r.delta <= RMW_DELW_MAX'(req_delta[int'(gid_s)*DELW +: DELW]);
    end else begin
      st1_valid_r <= 1'b0;
      st1_r       <= st1_r;
    end
  end

  assign st1_id_s    = st1_r.id[IDW-1:0];
  assign st1_addr_s  = st1_r.addr[AW-1:0];
  assign st1_delta_s = st1_r.delta[DELW-1:0];
  // The record is sized for the widest configuration; upper bits stay zero.
  assign st1_unused_s = ^st1_r;

  // The previous op's write has landed by now, so this read needs no bypass.
  assign rd_s        = mem_r[st1_addr_s];
  assign delta_ext_s = DW'(st1_delta_s);

`ifdef RMW_SATURATE_EN
  // Clamp at all-ones when the carry out is set.
  always_comb begin
    sum_ext_s = {1'b0, rd_s} + {1'b0, delta_ext_s};
    if (sum_ext_s[DW]) begin
      sum_s = {DW{1'b1}};
      sat_s = 1'b1;
    end else begin
      sum_s = sum_ext_s[DW-1:0];
      sat_s = 1'b0;
    end
  end
`else
  // Modulo 2^DW update.
  always_comb begin
    sum_s = rd_s + delta_ext_s;
  end
`endif

  // Single write port: zeroing during INIT, otherwise the stage-1 update.
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      mem_r[init_ptr_r] <= {DW{1'b0}};
    end else if (st1_valid_r) begin
      mem_r[st1_addr_s] <= sum_s;
    end
  end

  // Stage 2 response registers; id/data hold between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= {IDW{1'b0}};
      rsp_data  <= {DW{1'b0}};
`ifdef RMW_SATURATE_EN
      sat_flag  <= 1'b0;
`endif
    end else if (st1_valid_r) begin
      rsp_valid <= 1'b1;
      rsp_id    <= st1_id_s;
      rsp_data  <= sum_s;
`ifdef RMW_SATURATE_EN
      sat_flag  <= sat_s;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= rsp_id;
      rsp_data  <= rsp_data;
`ifdef RMW_SATURATE_EN
      sat_flag  <= sat_flag;
`endif
    end
  end

endmodule

// File: tb/tb_rmw_counter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rmw_counter_arbiter
// Directed self-checking bench. DW is reduced to 16 so the wrap/saturate
// boundary can be reached by incrementing within a short run.
// ---------------------------------------------------------------------------
module tb_rmw_counter_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DELW  = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clr = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DELW-1:0] req_delta = '0;
  logic                 rsp_valid;
  logic [0:0]           rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 busy;
`ifdef RMW_SATURATE_EN
  logic                 sat_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rmw_counter_arbiter #(
    .NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .DW(DW), .DELW(DELW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_delta (req_delta),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef RMW_SATURATE_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [AW-1:0] a, input logic [DELW-1:0] d);
    req_addr[i*AW +: AW]      = a;
    req_delta[i*DELW +: DELW] = d;
  endtask

  // One request from requester i; returns when its response is visible.
  task automatic single(input int i, input logic [AW-1:0] a, input logic [DELW-1:0] d);
    drive(i, a, d);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    #1;
    step();
    req_valid = '0;
    step();
  endtask

  task automatic test_reset();
    int n, bad;
    reset_n = 1'b0;
    req_valid = 2'b01;
    drive(0, 3'd0, 8'd4);
    step(); step();
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    reset_n = 1'b1;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 20) begin
      if (req_ready !== 2'b00) bad++;
      step();
      n++;
    end
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL init_len: got %0d cycles want 8", n); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL init_ready: got %0d granted cycles want 0", bad); end
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL first_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL first_early: got %b want 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL first_id: got %b want 0", rsp_id); end
    n_cmp++; if (rsp_data !== 16'd4) begin n_err++; $display("FAIL first_data: got %0d want 4", rsp_data); end
  endtask

  task automatic test_latency();
    for (int r = 1; r <= 2; r++) begin
      drive(0, 3'd3, 8'd5);
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL lat_ready: got %b want 01", req_ready); end
      step();
      req_valid = 2'b00;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1: got %b want 0", rsp_valid); end
      step();
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lat_n2: got %b want 1", rsp_valid); end
      n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL lat_id: got %b want 0", rsp_id); end
      n_cmp++; if (rsp_data !== 16'(5 * r)) begin n_err++; $display("FAIL lat_data: got %0d want %0d", rsp_data, 5 * r); end
    end
  endtask

  // Pointer sits at 1 after the earlier requester-0 grants, so 1 wins first.
  task automatic test_alternate();
    int j;
    drive(0, 3'd1, 8'd1);
    drive(1, 3'd2, 8'd1);
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 10) ? 2'b11 : 2'b00;
      #1;
      if (c < 10) begin
        n_cmp++;
        if (req_ready !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL alt_grant[%0d]: got %b want %b", c, req_ready, (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      step();
      if (c >= 1) begin
        j = c - 1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL alt_valid[%0d]: got %b want 1", j, rsp_valid); end
        n_cmp++; if (rsp_id !== ((j % 2 == 0) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL alt_id[%0d]: got %b want %0d", j, rsp_id, (j % 2 == 0) ? 1 : 0); end
        n_cmp++; if (rsp_data !== 16'(j / 2 + 1)) begin n_err++; $display("FAIL alt_data[%0d]: got %0d want %0d", j, rsp_data, j / 2 + 1); end
      end
    end
    single(0, 3'd1, 8'd0);
    n_cmp++; if (rsp_data !== 16'd5) begin n_err++; $display("FAIL alt_final_a1: got %0d want 5", rsp_data); end
    single(1, 3'd2, 8'd0);
    n_cmp++; if (rsp_data !== 16'd5 || rsp_id !== 1'b1) begin n_err++; $display("FAIL alt_final_a2: got %0d id %b want 5 id 1", rsp_data, rsp_id); end
  endtask

  task automatic test_back_to_back();
    drive(0, 3'd7, 8'd1);
    for (int c = 0; c <= 5; c++) begin
      req_valid = (c < 4) ? 2'b01 : 2'b00;
      step();
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'(c)) begin
          n_err++; $display("FAIL b2b[%0d]: got valid %b data %0d want 1 / %0d", c, rsp_valid, rsp_data, c);
        end
      end else if (c == 5) begin
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail: got %b want 0", rsp_valid); end
      end
    end
  endtask

  // Entry 0 holds 4: 4 + 256*255 + 250 = 0xFFFE, then +3 crosses the top.
  task automatic test_wrap();
    drive(0, 3'd0, 8'd255);
    for (int k = 0; k <= 256; k++) begin
      if (k == 256) drive(0, 3'd0, 8'd250);
      req_valid = 2'b01;
      step();
    end
    req_valid = 2'b00;
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFFE) begin n_err++; $display("FAIL preload: got valid %b data %h want 1 / fffe", rsp_valid, rsp_data); end
`ifdef RMW_SATURATE_EN
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL preload_sat: got %b want 0", sat_flag); end
`endif
    single(0, 3'd0, 8'd3);
`ifdef RMW_SATURATE_EN
    n_cmp++; if (rsp_data !== 16'hFFFF) begin n_err++; $display("FAIL saturate: got %h want ffff", rsp_data); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
`else
    n_cmp++; if (rsp_data !== 16'h0001) begin n_err++; $display("FAIL wrap: got %h want 0001", rsp_data); end
`endif
  endtask

  task automatic test_clr();
    int n, bad;
    drive(0, 3'd3, 8'd2);
    req_valid = 2'b01;
    step();
    clr = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL clr_ready: got %b want 00", req_ready); end
    step();
    clr = 1'b0;
    req_valid = 2'b00;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd12) begin n_err++; $display("FAIL clr_inflight: got valid %b data %0d want 1 / 12", rsp_valid, rsp_data); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clr_busy: got %b want 1", busy); end
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      if (rsp_valid !== 1'b0) bad++;
      n++;
    end
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL clr_init_len: got %0d cycles want 8", n); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL clr_spurious: got %0d responses want 0", bad); end
    single(0, 3'd3, 8'd2);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd2) begin n_err++; $display("FAIL clr_after: got valid %b data %0d want 1 / 2", rsp_valid, rsp_data); end
  endtask

  task automatic test_reset_midop();
    int n;
    drive(0, 3'd3, 8'd1);
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL midrst_now: got valid %b busy %b want 0 / 1", rsp_valid, busy); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_drop: got %b want 0", rsp_valid); end
    reset_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_cmp++; if (n !== 8) begin n_err++; $display("FAIL midrst_init_len: got %0d cycles want 8", n); end
    single(0, 3'd3, 8'd0);
    n_cmp++; if (rsp_data !== 16'd0) begin n_err++; $display("FAIL midrst_zeroed: got %0d want 0", rsp_data); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_alternate();
    test_back_to_back();
    test_wrap();
    test_clr();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
